// File: rtl/scan_bus_bridge.sv
// rtl/scan_bus_bridge.sv - scan-chain command responder issuing one bus transaction per scan_id toggle
// Toggle detection runs only in IDLE; outputs are registered and cleared asynchronously by rst.

module scan_bus_bridge #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_id,
  input  logic              cfg_wen,
  input  logic              cfg_ren,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_ready,
  output logic              scan_err,
  output logic              busy,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_rdata
);

  typedef enum logic [2:0] {INIT, IDLE, REQ, RSP, DONE} state_t;

  localparam int CNT_MAX = (TIMEOUT > SYNC_STAGES) ? TIMEOUT : SYNC_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   id_s;
  logic                   id_seen, id_seen_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [DATA_W-1:0]      scan_rdata_n;
  logic                   scan_ready_n, scan_err_n, busy_n;
  logic                   bus_req_valid_n, bus_we_n;
  logic [ADDR_W-1:0]      bus_addr_n;
  logic [DATA_W-1:0]      bus_wdata_n;

  assign id_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= INIT;
      sync          <= '0;
      id_seen       <= 1'b0;
      cnt           <= '0;
      scan_rdata    <= '0;
      scan_ready    <= 1'b0;
      scan_err      <= 1'b0;
      busy          <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
    end else begin
      state         <= state_n;
      sync          <= {sync[SYNC_STAGES-2:0], scan_id};
      id_seen       <= id_seen_n;
      cnt           <= cnt_n;
      scan_rdata    <= scan_rdata_n;
      scan_ready    <= scan_ready_n;
      scan_err      <= scan_err_n;
      busy          <= busy_n;
      bus_req_valid <= bus_req_valid_n;
      bus_we        <= bus_we_n;
      bus_addr      <= bus_addr_n;
      bus_wdata     <= bus_wdata_n;
    end
  end

  always_comb begin
    state_n         = state;
    id_seen_n       = id_seen;
    cnt_n           = cnt;
    scan_rdata_n    = scan_rdata;
    scan_ready_n    = scan_ready;
    scan_err_n      = scan_err;
    bus_req_valid_n = bus_req_valid;
    bus_we_n        = bus_we;
    bus_addr_n      = bus_addr;
    bus_wdata_n     = bus_wdata;

    case (state)
      // Let the synchronizer settle so a high scan_id at reset release is not a toggle.
      INIT: begin
        if (cnt == INIT_LAST) begin
          id_seen_n = id_s;
          cnt_n     = '0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      IDLE: begin
        if (id_s != id_seen) begin
          id_seen_n    = id_s;
          scan_ready_n = 1'b0;
          scan_err_n   = 1'b0;
          cnt_n        = '0;
          if (cfg_wen && !cfg_ren) begin
            bus_we_n        = 1'b1;
            bus_addr_n      = cfg_addr;
            bus_wdata_n     = cfg_wdata;
            bus_req_valid_n = 1'b1;
            state_n         = REQ;
          end else if (!cfg_wen && cfg_ren) begin
            bus_we_n        = 1'b0;
            bus_addr_n      = cfg_addr;
            bus_wdata_n     = '0;
            bus_req_valid_n = 1'b1;
            state_n         = REQ;
          end else begin
            scan_err_n   = 1'b1;
            scan_ready_n = 1'b1;
            state_n      = DONE;
          end
        end
      end

      REQ: begin
        if (bus_req_ready) begin
          bus_req_valid_n = 1'b0;
          cnt_n           = '0;
          if (bus_we) begin
            scan_ready_n = 1'b1;
            state_n      = DONE;
          end else begin
            state_n = RSP;
          end
        end else if (cnt == TO_LAST) begin
          bus_req_valid_n = 1'b0;
          scan_err_n      = 1'b1;
          scan_ready_n    = 1'b1;
          cnt_n           = '0;
          if (!bus_we) scan_rdata_n = '1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RSP: begin
        if (bus_rsp_valid) begin
          scan_rdata_n = bus_rsp_rdata;
          scan_ready_n = 1'b1;
          state_n      = DONE;
        end else if (cnt == TO_LAST) begin
          scan_rdata_n = '1;
          scan_err_n   = 1'b1;
          scan_ready_n = 1'b1;
          cnt_n        = '0;
          state_n      = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      DONE: state_n = IDLE;

      default: state_n = INIT;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_scan_bus_bridge.sv
// tb/tb_scan_bus_bridge.sv - directed bench for scan_bus_bridge
// Inputs change and outputs are sampled on the falling clock edge.

module tb_scan_bus_bridge;

  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_id;
  logic          cfg_wen, cfg_ren;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic [DW-1:0] scan_rdata;
  logic          scan_ready, scan_err, busy;
  logic          bus_req_valid, bus_req_ready, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_rsp_valid;
  logic [DW-1:0] bus_rsp_rdata;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mem [0:15];

  scan_bus_bridge #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .scan_id(scan_id),
    .cfg_wen(cfg_wen), .cfg_ren(cfg_ren), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .scan_rdata(scan_rdata), .scan_ready(scan_ready), .scan_err(scan_err), .busy(busy),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus_req_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic write_txn(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat;
    cfg_wen = 1'b1; cfg_ren = 1'b0; cfg_addr = a; cfg_wdata = d;
    bus_req_ready = 1'b1;
    scan_id = ~scan_id;
    wait_valid(lat);
    chk("wr_latency", 64'(lat), 64'd3);
    chk("wr_we", 64'(bus_we), 64'd1);
    chk("wr_addr", 64'(bus_addr), 64'(a));
    chk("wr_data", 64'(bus_wdata), 64'(d));
    mem[bus_addr[3:0]] = bus_wdata;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("wr_valid_drop", 64'(bus_req_valid), 64'd0);
    chk("wr_ready", 64'(scan_ready), 64'd1);
    chk("wr_err", 64'(scan_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic read_txn(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int lat;
    cfg_wen = 1'b0; cfg_ren = 1'b1; cfg_addr = a; cfg_wdata = 32'hDEAD_BEEF;
    bus_req_ready = 1'b1;
    scan_id = ~scan_id;
    wait_valid(lat);
    chk("rd_latency", 64'(lat), 64'd3);
    chk("rd_we", 64'(bus_we), 64'd0);
    chk("rd_addr", 64'(bus_addr), 64'(a));
    chk("rd_ready_cleared", 64'(scan_ready), 64'd0);
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("rd_valid_drop", 64'(bus_req_valid), 64'd0);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = mem[a[3:0]];
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0;
    chk("rd_data", 64'(scan_rdata), 64'(exp));
    chk("rd_ready", 64'(scan_ready), 64'd1);
    chk("rd_err", 64'(scan_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat, m, pulses;
    rst = 1'b1; scan_id = 1'b0; cfg_wen = 1'b0; cfg_ren = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_rdata", 64'(scan_rdata), 64'd0);
    chk("rst_ready", 64'(scan_ready), 64'd0);
    chk("rst_err", 64'(scan_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(bus_req_valid), 64'd0);
    chk("rst_we", 64'(bus_we), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_wdata", 64'(bus_wdata), 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(bus_req_valid), 64'd0);

    // write without stall
    write_txn(20'h00000, 32'h8765_4321);
    chk("wr_rdata_unchanged", 64'(scan_rdata), 64'd0);

    // read with a five-cycle request stall, response two cycles after accept
    cfg_wen = 1'b0; cfg_ren = 1'b1; cfg_addr = 20'h00480; bus_req_ready = 1'b0;
    scan_id = ~scan_id;
    wait_valid(lat);
    chk("stall_latency", 64'(lat), 64'd3);
    chk("stall_we", 64'(bus_we), 64'd0);
    chk("stall_wdata", 64'(bus_wdata), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid_held", 64'(bus_req_valid), 64'd1);
      chk("stall_addr_held", 64'(bus_addr), 64'h00480);
      @(negedge clk);
    end
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("stall_valid_drop", 64'(bus_req_valid), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_ready_low", 64'(scan_ready), 64'd0);
    @(negedge clk);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0000_0001;
    @(negedge clk);
    bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    chk("stall_rdata", 64'(scan_rdata), 64'h1);
    chk("stall_ready", 64'(scan_ready), 64'd1);
    chk("stall_err", 64'(scan_err), 64'd0);
    repeat (2) @(negedge clk);

    // illegal: both enables set
    cfg_wen = 1'b1; cfg_ren = 1'b1; bus_req_ready = 1'b1;
    scan_id = ~scan_id;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_req_valid === 1'b1) pulses++;
    end
    chk("ill_no_valid", 64'(pulses), 64'd0);
    chk("ill_err", 64'(scan_err), 64'd1);
    chk("ill_ready", 64'(scan_ready), 64'd1);
    chk("ill_rdata_unchanged", 64'(scan_rdata), 64'h1);

    // read timeout: accepted but no response
    cfg_wen = 1'b0; cfg_ren = 1'b1; cfg_addr = 20'h00010; bus_req_ready = 1'b1;
    scan_id = ~scan_id;
    wait_valid(lat);
    chk("to_latency", 64'(lat), 64'd3);
    @(negedge clk);
    bus_req_ready = 1'b0;
    m = 0;
    while (scan_ready !== 1'b1 && m < 400) begin
      @(negedge clk);
      m++;
    end
    chk("to_cycles", 64'(m), 64'(TMO));
    chk("to_err", 64'(scan_err), 64'd1);
    chk("to_rdata", 64'(scan_rdata), 64'hFFFF_FFFF);
    chk("to_valid", 64'(bus_req_valid), 64'd0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    @(negedge clk);
    chk("late_rsp_ignored", 64'(scan_rdata), 64'hFFFF_FFFF);
    write_txn(20'h00005, 32'hA5A5_A5A5);
    chk("post_to_rdata", 64'(scan_rdata), 64'hFFFF_FFFF);

    // reset during REQ, release with scan_id high
    cfg_wen = 1'b0; cfg_ren = 1'b1; cfg_addr = 20'h00123; bus_req_ready = 1'b0;
    scan_id = ~scan_id;
    wait_valid(lat);
    @(negedge clk);
    chk("mid_valid", 64'(bus_req_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus_req_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_addr", 64'(bus_addr), 64'd0);
    chk("arst_ready", 64'(scan_ready), 64'd0);
    chk("arst_err", 64'(scan_err), 64'd0);
    chk("arst_rdata", 64'(scan_rdata), 64'd0);
    scan_id = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_req_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_req_valid === 1'b1) pulses++;
    end
    chk("rel_high_no_txn", 64'(pulses), 64'd0);
    cfg_wen = 1'b1; cfg_ren = 1'b0; cfg_addr = 20'h00007; cfg_wdata = 32'hCAFE_F00D;
    scan_id = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_req_valid === 1'b1) pulses++;
    end
    chk("toggle_one_txn", 64'(pulses), 64'd1);
    chk("toggle_ready", 64'(scan_ready), 64'd1);
    bus_req_ready = 1'b0;

    // back-to-back write/read pairs
    write_txn(20'h00001, 32'h1111_1111);
    read_txn(20'h00001, 32'h1111_1111);
    write_txn(20'h00002, 32'h2222_2222);
    read_txn(20'h00002, 32'h2222_2222);
    write_txn(20'h00003, 32'h3333_3333);
    read_txn(20'h00003, 32'h3333_3333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_bus_bridge.md
Name: scan_bus_bridge

Overview:
- Chip-side responder for the scan-chain host interface; runs in the core `clk` domain.
- Takes the static command fields shifted in over scan (wen, ren, addr, wdata) and waits for the host to toggle `scan_id`.
- On each toggle it issues exactly one transaction on the internal register/SRAM bus, then returns rdata and ready/error status for capture back into the scan chain.

Parameters:
- ADDR_W, 20, bus/scan address width
- DATA_W, 32, bus/scan data width
- SYNC_STAGES, 2, flops in the scan_id synchronizer (≥2)
- TIMEOUT, 255, max cycles waiting on bus_req_ready or bus_rsp_valid before abort

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- scan_id  in  1  host toggle strobe, asynchronous to clk
- cfg_wen  in  1  static write enable from scan chain
- cfg_ren  in  1  static read enable from scan chain
- cfg_addr  in  ADDR_W  static address from scan chain
- cfg_wdata  in  DATA_W  static write data from scan chain
- scan_rdata  out  DATA_W  read result, captured into chain rdata field
- scan_ready  out  1  transaction complete, captured into chain ready field
- scan_err  out  1  last transaction illegal or timed out
- busy  out  1  high in any state other than IDLE
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  ADDR_W  request address
- bus_wdata  out  DATA_W  request write data
- bus_rsp_valid  in  1  read response valid
- bus_rsp_rdata  in  DATA_W  read response data

Behaviour:
- Reset (async, active-high):
  - All outputs are 0: scan_rdata=0, scan_ready=0, scan_err=0, busy=0, bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - Synchronizer flops and id_seen are 0; state = INIT.
- Synchronizer: scan_id passes through SYNC_STAGES flops to give id_s. cfg_* are quasi-static (loaded before the toggle) and are not synchronized.
- States: INIT, IDLE, REQ, RSP, DONE.
- INIT:
  - Counts SYNC_STAGES+1 cycles, then sets id_seen ← id_s and moves to IDLE. No transaction is launched.
  - A high scan_id level at reset release therefore causes no spurious access.
- IDLE:
  - A toggle is detected when id_s ≠ id_seen.
  - On detection: id_seen ← id_s; clear scan_ready and scan_err; snapshot cfg_* into internal registers.
  - If wen=1, ren=0: load bus_we=1, bus_addr, bus_wdata; go to REQ.
  - If wen=0, ren=1: load bus_we=0, bus_addr, bus_wdata=0; go to REQ.
  - Otherwise (both or neither set): set scan_err=1, go to DONE, no bus activity.
- REQ:
  - bus_req_valid=1. bus_we, bus_addr and bus_wdata are held stable until accepted.
  - On bus_req_ready: deassert valid next cycle. A write goes to DONE; a read goes to RSP.
- RSP: on bus_rsp_valid, scan_rdata ← bus_rsp_rdata, then go to DONE.
- DONE: scan_ready=1 for one cycle's entry, then go to IDLE. scan_ready stays 1 until the next detected toggle.
- scan_rdata:
  - Updated only by a successful read or a read timeout.
  - Unchanged by writes and illegal commands.
- Latency:
  - First bus_req_valid appears SYNC_STAGES+1 clk cycles after the scan_id edge.
  - scan_ready rises 1 cycle after the handshake completes for a write, and 1 cycle after bus_rsp_valid for a read.
- Timeout:
  - A cycle counter resets on entry to REQ and on entry to RSP.
  - If it reaches TIMEOUT in either state: drop bus_req_valid, set scan_err=1 and scan_ready=1, go to IDLE.
  - A timed-out read sets scan_rdata to all-ones.
  - A late bus_rsp_valid in IDLE is ignored.
- Toggles while busy:
  - Detection happens only in IDLE, so a toggle that arrives during a transaction is serviced after completion.
  - Two toggles during one transaction cancel and produce no access. This is acceptable because the host waits many cycles between toggles.
- Reset mid-transaction: abort immediately to INIT with all outputs 0. No bus handshake completion is required.

Test Plan:
- Write, no stall:
  - Stimulus: cfg_wen=1, cfg_ren=0, addr=0x00000, wdata=0x87654321; toggle scan_id; bus_req_ready tied 1.
  - Required: a single valid pulse with bus_we=1, addr 0x00000, data 0x87654321, appearing 3 cycles after the edge; scan_ready=1 next; scan_rdata unchanged.
- Read with stall:
  - Stimulus: read addr 0x00480; bus_req_ready held 0 for 5 cycles; response 0x00000001 two cycles after accept.
  - Required: valid and addr held stable through the stall; scan_rdata=0x00000001; scan_ready=1; scan_err=0.
- Illegal command:
  - Stimulus: cfg_wen=cfg_ren=1, then toggle.
  - Required: no bus_req_valid; scan_err=1; scan_ready=1.
- Timeout:
  - Stimulus: read with bus_rsp_valid never asserted.
  - Required: scan_ready=1, scan_err=1, scan_rdata=0xFFFFFFFF, exactly TIMEOUT cycles after accept. A following legal write completes normally with scan_err cleared.
- Reset handling:
  - Stimulus: assert rst during REQ.
  - Required: bus_req_valid drops asynchronously and all outputs are 0.
  - Stimulus: release rst with scan_id=1.
  - Required: no transaction. A subsequent toggle to 0 triggers exactly one transaction.
- Back-to-back:
  - Stimulus: writes to 0x00001, 0x00002, 0x00003, each followed by a read of the same address.
  - Required: each read returns the value written; scan_ready clears at each new toggle.
